// File: rtl/wb_init_pkg.sv
// Shared types for the Wishbone initiator: FSM state encoding, the registered
// command, and the registered response.
package wb_init_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RETRY = 2'd2,
    RESP  = 2'd3
  } wbi_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } wbi_cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } wbi_rsp_t;

endpackage

// File: rtl/wishbone_interface.sv
// Wishbone classic-cycle bundle; the initiator uses the master modport.
interface wishbone_interface;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_mosi;
  logic [31:0] dat_miso;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, we, adr, sel, dat_mosi,
                  input  dat_miso, ack, err);
  modport slave  (input  cyc, stb, we, adr, sel, dat_mosi,
                  output dat_miso, ack, err);
endinterface

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: down-counter loaded with LIMIT-1, saturating at zero;
// expired is the terminal-count compare (LIMIT enabled cycles after clr).
module wb_timeout_ctr #(
  parameter int LIMIT = 512
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT) + 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= W'(LIMIT - 1);
    end else if (clr) begin
      cnt <= W'(LIMIT - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/wishbone_initiator.sv
// Single-outstanding Wishbone classic-cycle initiator (valid/ready cmd in, rsp out).
// Optional retry-on-err is enabled by defining WB_INIT_RETRY_EN.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// BUS   | cyc/stb asserted with the registered command, waiting for ack/err/timeout
// RETRY | one idle bus cycle before re-issuing after err (WB_INIT_RETRY_EN only)
// RESP  | rsp_valid high, response held until rsp_ready
import wb_init_pkg::*;

module wishbone_initiator #(
  parameter int TIMEOUT_CYCLES = 512,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [31:0]         cmd_adr,
  input  logic [3:0]          cmd_sel,
  input  logic [31:0]         cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  wishbone_interface.master   wb
);

  wbi_state_e state, state_nxt;
  wbi_cmd_t   cmd_q;
  wbi_rsp_t   rsp_q;
  logic       tmo_expired;
  logic       retry_ok;

  wb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state == IDLE) || (state == RETRY)),
    .en      (state == BUS),
    .expired (tmo_expired)
  );

`ifdef WB_INIT_RETRY_EN
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  logic [RW-1:0] retry_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (state == IDLE) begin
      retry_cnt <= '0;
    end else if (state == RETRY) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end

  assign retry_ok = (retry_cnt < RW'(MAX_RETRIES));
`else
  logic unused_cfg;
  assign unused_cfg = ^MAX_RETRIES;
  assign retry_ok   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // err has priority over ack; timeout only counts when neither arrives.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cmd_valid) state_nxt = BUS;
      BUS: begin
        if (wb.err)                      state_nxt = retry_ok ? RETRY : RESP;
        else if (wb.ack || tmo_expired)  state_nxt = RESP;
      end
      RETRY: state_nxt = BUS;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    wb.cyc    = (state == BUS);
    wb.stb    = (state == BUS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q <= '0;
      rsp_q <= '0;
    end else begin
      if ((state == IDLE) && cmd_valid) begin
        cmd_q <= '{we: cmd_we, adr: cmd_adr, sel: cmd_sel, wdata: cmd_wdata};
      end
      if ((state == BUS) && (state_nxt == RESP)) begin
        rsp_q.err     <= wb.err || !wb.ack;
        rsp_q.timeout <= !wb.err && !wb.ack;
        rsp_q.rdata   <= (!wb.err && wb.ack && !cmd_q.we) ? wb.dat_miso : 32'd0;
      end
    end
  end

  assign wb.we       = cmd_q.we;
  assign wb.adr      = cmd_q.adr;
  assign wb.sel      = cmd_q.sel;
  assign wb.dat_mosi = cmd_q.wdata;

  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_wishbone_initiator.sv
// Directed bench for wishbone_initiator (TIMEOUT_CYCLES=16); retry sequences
// are exercised when WB_INIT_RETRY_EN is defined.
module tb_wishbone_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  int n_vec = 0;
  int n_err = 0;

  wishbone_interface wb_if ();

  wishbone_initiator #(.TIMEOUT_CYCLES(16), .MAX_RETRIES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_adr     (cmd_adr),
    .cmd_sel     (cmd_sel),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .wb          (wb_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_sel   = sel;
    cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_sel = 0; cmd_wdata = 0;
    rsp_ready = 0;
    wb_if.ack = 0; wb_if.err = 0; wb_if.dat_miso = 0;
    tick(); tick();

    // reset values: {cyc,stb,we,sel,adr,dat_mosi}, then handshake/response
    chk("rst_bus", {wb_if.cyc, wb_if.stb, wb_if.we, wb_if.sel, wb_if.adr, wb_if.dat_mosi},
        {3'b000, 4'h0, 32'h0, 32'h0});
    chk("rst_rsp", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout},
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
    rst = 1'b0;
    tick();

    // read, ack on first stb cycle
    chk("rd_cmd_ready", cmd_ready, 1);
    issue(1'b0, 32'h0000_0010, 4'hF, 32'hAAAA_5555);
    chk("rd_bus", {wb_if.cyc, wb_if.stb, wb_if.we, wb_if.adr, rsp_valid},
        {3'b110, 32'h0000_0010, 1'b0});
    wb_if.ack = 1; wb_if.dat_miso = 32'hDEAD_BEEF;
    tick();
    wb_if.ack = 0; wb_if.dat_miso = 0;
    chk("rd_rsp", {wb_if.cyc, rsp_valid, rsp_rdata, rsp_err, rsp_timeout},
        {1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0});
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("rd_done", {rsp_valid, cmd_ready}, 2'b01);

    // write, ack after 5 wait states; cmd inputs change but must be ignored
    issue(1'b1, 32'h2000_0004, 4'b0011, 32'h1234_5678);
    cmd_adr = 32'hFFFF_FFFF; cmd_wdata = 0; cmd_sel = 4'hF; cmd_we = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("wr_stable_%0d", i),
          {wb_if.cyc, wb_if.stb, wb_if.we, wb_if.sel, wb_if.adr, wb_if.dat_mosi},
          {3'b111, 4'b0011, 32'h2000_0004, 32'h1234_5678});
      if (i == 5) wb_if.ack = 1;
      tick();
    end
    wb_if.ack = 0;
    chk("wr_rsp", {wb_if.cyc, rsp_valid, rsp_rdata, rsp_err, rsp_timeout},
        {1'b0, 1'b1, 32'h0, 1'b0, 1'b0});
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // timeout: exactly 16 BUS cycles
    issue(1'b0, 32'h0000_0030, 4'hF, 32'h0);
    n = 0;
    while (wb_if.cyc === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout},
        {1'b1, 32'h0, 1'b1, 1'b1});
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // ack on the 16th BUS cycle beats the timeout
    issue(1'b0, 32'h0000_0040, 4'hF, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_edge_cyc", wb_if.cyc, 1);
    wb_if.ack = 1; wb_if.dat_miso = 32'hCAFE_F00D;
    tick();
    wb_if.ack = 0; wb_if.dat_miso = 0;
    chk("tmo_edge_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout},
        {1'b1, 32'hCAFE_F00D, 1'b0, 1'b0});
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

`ifndef WB_INIT_RETRY_EN
    // ack and err together: err wins; response held while rsp_ready low
    issue(1'b0, 32'h0000_0050, 4'hF, 32'h0);
    wb_if.ack = 1; wb_if.err = 1; wb_if.dat_miso = 32'h5555_AAAA;
    tick();
    wb_if.ack = 0; wb_if.err = 0; wb_if.dat_miso = 0;
    cmd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("err_hold_%0d", i),
          {wb_if.cyc, cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout},
          {1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0});
      tick();
    end
    cmd_valid = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("err_done", {rsp_valid, cmd_ready, wb_if.cyc}, 3'b010);
`else
    // err, err, ack: three bursts separated by one idle cycle
    issue(1'b0, 32'h0000_0060, 4'hF, 32'h0);
    chk("rty_b1", wb_if.cyc, 1);
    wb_if.err = 1; tick(); wb_if.err = 0;
    chk("rty_gap1", {wb_if.cyc, rsp_valid}, 2'b00);
    tick();
    chk("rty_b2", wb_if.cyc, 1);
    wb_if.err = 1; tick(); wb_if.err = 0;
    chk("rty_gap2", {wb_if.cyc, rsp_valid}, 2'b00);
    tick();
    chk("rty_b3", wb_if.cyc, 1);
    wb_if.ack = 1; wb_if.dat_miso = 32'h0BAD_F00D; tick(); wb_if.ack = 0;
    chk("rty_ok_rsp", {wb_if.cyc, rsp_valid, rsp_rdata, rsp_err},
        {1'b0, 1'b1, 32'h0BAD_F00D, 1'b0});
    rsp_ready = 1; tick(); rsp_ready = 0;

    // err on all three attempts
    issue(1'b1, 32'h0000_0070, 4'hF, 32'h1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (wb_if.cyc === 1'b1) n++;
      wb_if.err = wb_if.cyc;
      tick();
    end
    wb_if.err = 0;
    chk("rty_bursts", n, 3);
    chk("rty_fail_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout},
        {1'b1, 32'h0, 1'b1, 1'b0});
    rsp_ready = 1; tick(); rsp_ready = 0;
`endif

    // reset mid-BUS drops cyc/stb asynchronously, no response follows
    issue(1'b1, 32'h0000_0080, 4'hF, 32'h7777_7777);
    chk("rstm_bus", wb_if.cyc, 1);
    #2 rst = 1;
    #1;
    chk("rstm_async", {wb_if.cyc, wb_if.stb, rsp_valid}, 3'b000);
    tick();
    rst = 0;
    tick();
    chk("rstm_after", {cmd_ready, rsp_valid, wb_if.cyc}, 3'b100);
    tick(); tick();
    chk("rstm_norsp", {rsp_valid, wb_if.cyc}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wishbone_initiator.md
# wishbone_initiator

Single-outstanding Wishbone classic-cycle initiator that turns commands from a simple valid/ready port into bus transactions toward the interconnect's master-facing slave port. It holds `cyc`/`stb` until `ack`, `err`, or a local timeout, then returns a response on a valid/ready port. It sits between on-chip masters (CPU load/store unit, DMA, CNN accelerator control) and the Wishbone interconnect.

## Interface
- `TIMEOUT_CYCLES`, default 512: bus cycles in BUS before local abort. Must exceed the interconnect timeout (255) so that the interconnect `err` normally wins.
- `MAX_RETRIES`, default 2: retries after `err`. Used only with `WB_INIT_RETRY_EN`.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high with `cmd_valid`.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_adr` in 32: byte address.
- `cmd_sel` in 4: byte enables.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when high with `rsp_valid`.
- `rsp_rdata` out 32: read data. It is 0 for writes and for errors.
- `rsp_err` out 1: the transaction failed (bus `err` or timeout).
- `rsp_timeout` out 1: the failure was the local timeout.
- `wb` wishbone_interface.master: drives `cyc`, `stb`, `adr`, `sel`, `we`, `dat_mosi`; samples `dat_miso`, `ack`, `err`.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1. On handshake, register `adr`/`sel`/`we`/`wdata`, clear the timeout counter and retry count, then go to BUS.
  - BUS: `cyc`=`stb`=1, and the bus outputs stay stable. Sample each cycle:
    - `err` → RETRY if retries remain (macro on only), else RESP with `rsp_err`=1.
    - `ack` → RESP with `rsp_err`=0. On a read, `rsp_rdata` = `dat_miso` captured that cycle.
    - counter == `TIMEOUT_CYCLES`-1 with no `ack`/`err` → RESP with `rsp_err`=1 and `rsp_timeout`=1.
  - RETRY (macro on only): `cyc`=`stb`=0 for exactly one cycle, increment the retry count, clear the timeout counter, go back to BUS with the same registered command.
  - RESP: `rsp_valid`=1, and the response fields are held stable until `rsp_ready`. Then go to IDLE.
- `ack` and `err` in the same cycle: `err` wins.
- Timeout: the counter only advances in BUS and saturates. It is sized `$clog2(TIMEOUT_CYCLES)+1`.
- `rsp_timeout` implies `rsp_err`. Timeouts are never retried.
- `wb.dat_mosi` is driven with the registered `wdata` for reads too; the value is don't-care on reads.
- `cmd_*` inputs are ignored outside IDLE.

## Timing
- Reset values: `cyc`=`stb`=`we`=0, `adr`=`sel`=`dat_mosi`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=`rsp_timeout`=0. FSM state is IDLE.
- Cycle 0: `cmd` handshake.
- Cycle 1: `cyc`/`stb` high.
- If `ack` arrives in cycle k≥1, `rsp_valid` rises in cycle k+1 and `cyc`/`stb` drop in cycle k+1.
- Minimum command-to-response latency is 2 cycles. Minimum throughput is one transaction per 3 cycles (IDLE, BUS, RESP).
- Every bus output is registered. No combinational path from `ack`/`err` to `cyc`/`stb`.
- Reset asserted mid-transaction drops `cyc`/`stb` immediately (asynchronously). The pending command is discarded and no response is produced.
- `rsp_ready` held high: RESP lasts exactly one cycle.

## Configuration
- `WB_INIT_RETRY_EN` defined:
  - RETRY state exists.
  - An `err` response is retried up to `MAX_RETRIES` times, each retry preceded by one idle bus cycle.
  - The final `err` is reported with `rsp_err`=1.
- `WB_INIT_RETRY_EN` undefined:
  - No RETRY state and no retry counter.
  - The first `err` goes directly to RESP.

## Structure
- Package `wb_init_pkg` holds:
  - the `wbi_state_e` enum (IDLE, BUS, RETRY, RESP);
  - the `wbi_cmd_t` struct (`we`, `adr`, `sel`, `wdata`);
  - the `wbi_rsp_t` struct (`rdata`, `err`, `timeout`).
- One sub-module, `wb_timeout_ctr`, with parameter `LIMIT` and ports:
  - `clk`, `rst`;
  - `clr`, `en`;
  - `expired`.
- The FSM and registers stay in the top module.

## Test plan
- Read at 0x0000_0010; slave acks on the first stb cycle with `dat_miso`=0xDEAD_BEEF → `rsp_valid` 2 cycles after the handshake, `rsp_rdata`=0xDEAD_BEEF, `rsp_err`=0.
- Write of 0x1234_5678 with `sel`=4'b0011; slave acks after 5 wait cycles → `adr`/`dat_mosi`/`sel`/`we` stable for all 6 stb cycles, `rsp_rdata`=0, `rsp_err`=0.
- No `ack`/`err` with `TIMEOUT_CYCLES`=16 → `cyc` drops after exactly 16 BUS cycles, `rsp_err`=1, `rsp_timeout`=1.
- `ack` and `err` asserted in the same cycle, macro off → `rsp_err`=1. Then hold `rsp_ready`=0 for 4 cycles → response fields stable and `cmd_ready`=0 throughout.
- Macro on, `MAX_RETRIES`=2, `err` on the first two attempts and `ack` on the third → 3 `stb` bursts separated by single idle cycles, `rsp_err`=0. If `err` on all 3 attempts → `rsp_err`=1.
- `rst` pulsed while in BUS → `cyc`/`stb` low in the same cycle, no `rsp_valid`, `cmd_ready`=1 after reset.
